// File: rtl/multiplier_pipe_pp_pkg.sv
// Shared definitions for the pipelined multiplier: operand mode encodings and
// an elaboration-time guard on the WIDTH/STAGES parameters.
`ifndef MULTIPLIER_PIPE_PP_DEFS
`define MULTIPLIER_PIPE_PP_DEFS

// Instantiated at module scope; elaboration stops on an unusable configuration.
`define MPP_CHECK_PARAMS(w, s) \
  if (((s) < 1) || ((w) < 2)) begin : gBadParams \
    $error("multiplier_pipe_pp: STAGES must be >= 1 and WIDTH must be >= 2"); \
  end

`endif

package multiplier_pipe_pp_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/multiplier_pipe_stage.sv
// One generic pipeline register with valid, stall, flush and async reset.
// Data only loads when the incoming valid is set, so bubbles leave it quiet.
module multiplier_pipe_stage
  import multiplier_pipe_pp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic         iEn,
  input  logic         iClr,
  input  logic         iValid,
  input  logic [W-1:0] iData,
  output logic         oValid,
  output logic [W-1:0] oData
);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (iClr) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (iEn) begin
      oValid <= iValid;
      if (iValid) begin
        oData <= iData;
      end
    end
  end

endmodule

// File: rtl/multiplier_pipe_pp.sv
// Pipelined WIDTH x WIDTH multiplier with per-transaction signed/unsigned mode,
// STAGES cycles of latency, global stall (iEn) and synchronous flush (iClr).
module multiplier_pipe_pp
  import multiplier_pipe_pp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic                 iValid,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iData0,
  input  logic [WIDTH-1:0]     iData1,
  output logic                 oValid,
  output logic                 oSigned,
  output logic [2*WIDTH-1:0]   oData
);

  // Every stage carries {mode, 2*WIDTH payload}; stage 1 packs {mode, b, a}.
  localparam int PW = 2 * WIDTH + 1;

  `MPP_CHECK_PARAMS(WIDTH, STAGES)

  // Extending both operands to full width makes the truncated product exact
  // for either interpretation, so one multiplier serves both modes.
  function automatic logic [2*WIDTH-1:0] mulExt(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn
  );
    logic signed [2*WIDTH-1:0] extA;
    logic signed [2*WIDTH-1:0] extB;
    logic signed [2*WIDTH-1:0] prod;
    if (sgn == MODE_SIGNED) begin
      extA = {{WIDTH{a[WIDTH-1]}}, a};
      extB = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      extA = {{WIDTH{1'b0}}, a};
      extB = {{WIDTH{1'b0}}, b};
    end
    prod = extA * extB;
    return prod;
  endfunction

  logic          vldOut;
  logic [PW-1:0] dataOut;

  if (STAGES == 1) begin : gSingle
    // Stage 0 -> 1: product of the raw inputs registered directly
    logic [PW-1:0] prod_p0;

    assign prod_p0 = {iSigned, mulExt(iData0, iData1, iSigned)};

    multiplier_pipe_stage #(.W(PW)) uProd (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iEn    (iEn),
      .iClr   (iClr),
      .iValid (iValid),
      .iData  (prod_p0),
      .oValid (vldOut),
      .oData  (dataOut)
    );
  end else begin : gPipe
    logic          vld_p1;
    logic [PW-1:0] ops_p1;
    logic [STAGES:1] vld_pk;
    logic [PW-1:0] data_pk [1:STAGES];

    // Stage 0 -> 1: operand register
    multiplier_pipe_stage #(.W(PW)) uOps (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iEn    (iEn),
      .iClr   (iClr),
      .iValid (iValid),
      .iData  ({iSigned, iData1, iData0}),
      .oValid (vld_p1),
      .oData  (ops_p1)
    );

    // Stage 1 -> 2: combinational extend-and-multiply feeds the product chain
    assign vld_pk[1]  = vld_p1;
    assign data_pk[1] = {ops_p1[PW-1],
                         mulExt(ops_p1[WIDTH-1:0], ops_p1[2*WIDTH-1:WIDTH], ops_p1[PW-1])};

    for (genvar k = 2; k <= STAGES; k++) begin : gStage
      multiplier_pipe_stage #(.W(PW)) uProd (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iValid (vld_pk[k-1]),
        .iData  (data_pk[k-1]),
        .oValid (vld_pk[k]),
        .oData  (data_pk[k])
      );
    end

    assign vldOut  = vld_pk[STAGES];
    assign dataOut = data_pk[STAGES];
  end

  assign oValid  = vldOut;
  assign oSigned = dataOut[PW-1];
  assign oData   = dataOut[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_pipe_pp.sv
// Directed bench for multiplier_pipe_pp: a STAGES=3 instance for latency, sign,
// stall, flush, bubble and reset cases plus a STAGES=1 instance.
module tb_multiplier_pipe_pp;

  logic        clk;
  logic        rstN;
  logic        en, clr, valid, sgn;
  logic [31:0] d0, d1;
  logic        oValid, oSigned;
  logic [63:0] oData;

  logic        en1, clr1, valid1, sgn1;
  logic [31:0] a1, b1;
  logic        oValid1, oSigned1;
  logic [63:0] oData1;

  int checks;
  int failures;

  multiplier_pipe_pp #(.WIDTH(32), .STAGES(3)) dut (
    .iClk    (clk),
    .iRstN   (rstN),
    .iEn     (en),
    .iClr    (clr),
    .iValid  (valid),
    .iSigned (sgn),
    .iData0  (d0),
    .iData1  (d1),
    .oValid  (oValid),
    .oSigned (oSigned),
    .oData   (oData)
  );

  multiplier_pipe_pp #(.WIDTH(32), .STAGES(1)) dut1 (
    .iClk    (clk),
    .iRstN   (rstN),
    .iEn     (en1),
    .iClr    (clr1),
    .iValid  (valid1),
    .iSigned (sgn1),
    .iData0  (a1),
    .iData1  (b1),
    .oValid  (oValid1),
    .oSigned (oSigned1),
    .oData   (oData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] x, input logic [31:0] y);
    valid = v;
    sgn   = s;
    d0    = x;
    d1    = y;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstN  = 1'b0;
    en = 1'b0; clr = 1'b0; valid = 1'b0; sgn = 1'b0; d0 = '0; d1 = '0;
    en1 = 1'b0; clr1 = 1'b0; valid1 = 1'b0; sgn1 = 1'b0; a1 = '0; b1 = '0;

    // Outputs held at zero during reset
    step();
    step();
    chk("rst_valid", {63'd0, oValid}, 64'd0);
    chk("rst_signed", {63'd0, oSigned}, 64'd0);
    chk("rst_data", oData, 64'd0);
    chk("rst_valid_s1", {63'd0, oValid1}, 64'd0);
    chk("rst_data_s1", oData1, 64'd0);
    rstN = 1'b1;
    step();

    // Latency: 7 x 6 unsigned appears on the third enabled edge
    en = 1'b1;
    drive(1'b1, 1'b0, 32'd7, 32'd6);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("lat_e1_valid", {63'd0, oValid}, 64'd0);
    step();
    chk("lat_e2_valid", {63'd0, oValid}, 64'd0);
    step();
    chk("lat_e3_valid", {63'd0, oValid}, 64'd1);
    chk("lat_e3_data", oData, 64'd42);
    step();
    chk("lat_drain_valid", {63'd0, oValid}, 64'd0);
    chk("lat_drain_hold", oData, 64'd42);

    // Sign corners, back to back with mixed modes
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
    step();
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("sgn_minmin_valid", {63'd0, oValid}, 64'd1);
    chk("sgn_minmin_data", oData, 64'h4000_0000_0000_0000);
    chk("sgn_minmin_mode", {63'd0, oSigned}, 64'd1);
    step();
    chk("uns_maxsq_valid", {63'd0, oValid}, 64'd1);
    chk("uns_maxsq_data", oData, 64'hFFFF_FFFE_0000_0001);
    chk("uns_maxsq_mode", {63'd0, oSigned}, 64'd0);
    step();
    chk("sgn_neg1x1_valid", {63'd0, oValid}, 64'd1);
    chk("sgn_neg1x1_data", oData, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sgn_neg1x1_mode", {63'd0, oSigned}, 64'd1);

    // Stall: 3 x 5 accepted, then four frozen cycles
    drive(1'b1, 1'b0, 32'd3, 32'd5);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {63'd0, oValid}, 64'd0);
      chk("stall_data", oData, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    en = 1'b1;
    step();
    chk("stall_e2_valid", {63'd0, oValid}, 64'd0);
    step();
    chk("stall_e3_valid", {63'd0, oValid}, 64'd1);
    chk("stall_e3_data", oData, 64'd15);
    en = 1'b0;
    step();
    step();
    chk("stall_hold_valid", {63'd0, oValid}, 64'd1);
    chk("stall_hold_data", oData, 64'd15);

    // Flush with two pairs in flight and iEn low
    en = 1'b1;
    drive(1'b1, 1'b1, 32'd2, 32'd3);
    step();
    drive(1'b1, 1'b0, 32'd4, 32'd5);
    step();
    drive(1'b1, 1'b1, 32'd6, 32'd7);
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("flush_valid", {63'd0, oValid}, 64'd0);
    chk("flush_data", oData, 64'd0);
    chk("flush_mode", {63'd0, oSigned}, 64'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_drain_valid", {63'd0, oValid}, 64'd0);
      chk("flush_drain_data", oData, 64'd0);
    end

    // Bubble between two valid pairs
    drive(1'b1, 1'b0, 32'd2, 32'd2);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'd3, 32'd3);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    chk("bub_a_valid", {63'd0, oValid}, 64'd1);
    chk("bub_a_data", oData, 64'd4);
    step();
    chk("bub_gap_valid", {63'd0, oValid}, 64'd0);
    chk("bub_gap_data", oData, 64'd4);
    step();
    chk("bub_b_valid", {63'd0, oValid}, 64'd1);
    chk("bub_b_data", oData, 64'd9);

    // Single-stage build: one-cycle latency
    en1 = 1'b1;
    valid1 = 1'b1; sgn1 = 1'b0; a1 = 32'h1234; b1 = 32'h10;
    step();
    chk("s1_valid", {63'd0, oValid1}, 64'd1);
    chk("s1_data", oData1, 64'h12340);
    chk("s1_mode", {63'd0, oSigned1}, 64'd0);
    sgn1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h1;
    step();
    chk("s1_neg_data", oData1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s1_neg_mode", {63'd0, oSigned1}, 64'd1);
    valid1 = 1'b0;
    step();
    chk("s1_bubble_valid", {63'd0, oValid1}, 64'd0);
    chk("s1_bubble_data", oData1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset between edges with a pair in flight
    drive(1'b1, 1'b1, 32'd5, 32'd7);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    #2;
    rstN = 1'b0;
    #1;
    chk("arst_valid", {63'd0, oValid}, 64'd0);
    chk("arst_data", oData, 64'd0);
    chk("arst_mode", {63'd0, oSigned}, 64'd0);
    chk("arst_data_s1", oData1, 64'd0);
    chk("arst_mode_s1", {63'd0, oSigned1}, 64'd0);
    step();
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_drain_valid", {63'd0, oValid}, 64'd0);
      chk("arst_drain_data", oData, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_pipe_pp.md
Name: multiplier_pipe_pp

Overview:
- Parametrised, pipelined successor to the team's single-cycle 32-bit product register.
- Multiplies two WIDTH-bit operands with a per-transaction signed/unsigned mode.
- Configurable latency of STAGES cycles; a valid bit travels alongside each operand pair; a global stall (iEn) and a synchronous flush (iClr) are provided.
- Sits between operand-fetch logic and accumulator/MAC consumers in the datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.
- STAGES, 3, pipeline depth = latency in enabled cycles; must be >= 1. STAGES=1 reproduces the single-register behaviour.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iEn  input  1  advance enable; 0 freezes the entire pipeline, including valids.
- iClr  input  1  synchronous flush; takes priority over iEn.
- iValid  input  1  operand pair valid; sampled only when iEn=1.
- iSigned  input  1  1 = both operands two's complement; 0 = both unsigned. Travels with the data.
- iData0  input  WIDTH  multiplicand.
- iData1  input  WIDTH  multiplier.
- oValid  output  1  oData carries a new result this cycle.
- oSigned  output  1  mode bit of the result on oData.
- oData  output  2*WIDTH  full-precision product.

Behaviour:
- Reset (iRstN=0, asynchronous): every stage register, valid bit, oValid, oSigned and oData is forced to 0 immediately. This applies mid-operation too; in-flight transactions are discarded with no partial output.
- Priority at each clock edge: reset > iClr > iEn > hold.
- iClr=1: all valid bits, stage data, oData and oSigned clear to 0 on the edge, regardless of iEn. An input presented in the same cycle is dropped.
- iEn=0 (iClr=0): all registers hold, and oValid holds its value. The consumer must qualify oValid with its own enable.
- iEn=1: valid bits shift one stage per cycle. Stage k data loads only when the incoming valid is 1; otherwise it holds (bubbles do not toggle the datapath).
- Pipeline structure:
  - STAGES>=2: stage 1 registers iData0, iData1 and iSigned. The product is computed combinationally from stage 1. Stages 2..STAGES carry the 2*WIDTH product.
  - STAGES=1: the product of the raw inputs is registered directly.
- Latency: a pair accepted at enabled edge N appears on oData with oValid=1 after exactly STAGES enabled edges. Stalled cycles do not count.
- Throughput: one pair per enabled cycle; no back-pressure output.
- oData holds the last valid result while oValid=0 (bubble or drained pipe).
- Arithmetic:
  - Unsigned mode: zero-extend both operands to 2*WIDTH and multiply.
  - Signed mode: sign-extend both operands to 2*WIDTH and multiply; the result is exact two's complement.
  - No overflow is possible; no truncation or rounding.
- Mixed-mode back-to-back transactions are legal; each carries its own iSigned.
- Boundary cases (WIDTH=32):
  - signed (-2^31)×(-2^31) = 0x4000_0000_0000_0000.
  - unsigned 0xFFFF_FFFF² = 0xFFFF_FFFE_0000_0001.
  - signed -1×-1 = 1.
  - signed -1×1 = all ones.

Decomposition:
- Shared header (guarded `define file): mode constants MODE_UNSIGNED=0, MODE_SIGNED=1, plus a parameter-check macro that flags STAGES<1 or WIDTH<2 at elaboration.
- Sub-module multiplier_pipe_stage: one generic register stage with valid, enable, clear, async reset and data-gating, parametrised by data width. Instantiated via generate for stages 2..STAGES, and once for the stage-1 operand register.
- Top level holds the combinational signed/unsigned extend-and-multiply between stage 1 and stage 2.

Test Plan:
- Reset/latency (STAGES=3, WIDTH=32): reset, then iValid=1, unsigned 7×6, iEn=1 held -> oValid=1 with oData=42 exactly 3 edges later; all outputs 0 during reset.
- Sign corners: consecutive signed (-2^31,-2^31), unsigned (0xFFFFFFFF,0xFFFFFFFF), signed (-1,1) -> in order 0x4000000000000000, 0xFFFFFFFE00000001, 0xFFFFFFFFFFFFFFFF; oSigned = 1, 0, 1.
- Stall: accept 3×5, drop iEn for 4 cycles after the first edge -> result 15 appears only after 3 enabled edges; oValid and oData frozen during the stall.
- Flush: two pairs in flight, assert iClr with iEn=0 -> next cycle oValid=0 and oData=0; neither result ever emerges.
- Bubbles and hold: valid 2×2, bubble, valid 3×3 -> oValid pattern 1,0,1; oData stays 4 through the bubble, then 9.
- Async reset mid-stream plus STAGES=1 build: deassert iRstN between edges -> outputs 0 immediately; STAGES=1 gives a 1-cycle latency result of 0x1234×0x10 = 0x12340.
